// File: rtl/alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_sequencer
// Purpose  : Hardwired control unit for the Datapath. Sequences fetch
//            (T0..T2) and execution (T3..T6) of register-register ALU ops,
//            unary ops (neg/not), mul/div, nop and halt. Outputs are a Moore
//            decode of the state plus the IR read back from the Datapath.
// Ports    : Clock, Reset          - clock, synchronous active-high reset
//            IR                    - instruction register from Datapath
//            Mem_ready             - memory data valid during fetch (T1)
//            Stop                  - halt after the current instruction
//            PCout..MDRout         - bus drive enables
//            MARin..LOin           - register load enables
//            IncPC, Read           - PC increment, memory read
//            Gra/Grb/Grc, Rin/Rout - register-field select, GP reg in/out
//            ALU_op                - ALU function code (nonzero only with Zin
//                                    in the execute state)
//            Run, Illegal          - executing / halted on undefined opcode
//            Instr_count           - retired-instruction counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      IR,
  input  logic             Mem_ready,
  input  logic             Stop,
  output logic             PCout,
  output logic             Zhighout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic [4:0]       ALU_op,
  output logic             Run,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instr_count
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_illegal;

  logic [4:0] w_opcode;
  logic       w_binary, w_unary, w_muldiv, w_nop, w_halt, w_undef;
  logic [4:0] w_alu_code;
  logic       w_final;
  logic       w_unused;

  assign w_opcode = IR[31:27];
  // Register fields are decoded by the Datapath's select-and-encode logic.
  assign w_unused = ^IR[26:0];

  // Instruction class and ALU function code from the opcode.
  always_comb begin
    w_binary   = 1'b0;
    w_unary    = 1'b0;
    w_muldiv   = 1'b0;
    w_nop      = 1'b0;
    w_halt     = 1'b0;
    w_undef    = 1'b0;
    w_alu_code = 5'd0;
    case (w_opcode)
      5'b00011: begin w_binary = 1'b1; w_alu_code = 5'd3;  end // add
      5'b00100: begin w_binary = 1'b1; w_alu_code = 5'd4;  end // sub
      5'b00101: begin w_binary = 1'b1; w_alu_code = 5'd1;  end // and
      5'b00110: begin w_binary = 1'b1; w_alu_code = 5'd2;  end // or
      5'b00111: begin w_binary = 1'b1; w_alu_code = 5'd5;  end // shr
      5'b01000: begin w_binary = 1'b1; w_alu_code = 5'd6;  end // shl
      5'b01001: begin w_binary = 1'b1; w_alu_code = 5'd7;  end // ror
      5'b01010: begin w_binary = 1'b1; w_alu_code = 5'd8;  end // rol
      5'b01111: begin w_muldiv = 1'b1; w_alu_code = 5'd9;  end // mul
      5'b10000: begin w_muldiv = 1'b1; w_alu_code = 5'd10; end // div
      5'b10001: begin w_unary  = 1'b1; w_alu_code = 5'd11; end // neg
      5'b10010: begin w_unary  = 1'b1; w_alu_code = 5'd12; end // not
      5'b11000: w_nop  = 1'b1;
      5'b11011: w_halt = 1'b1;
      default:  w_undef = 1'b1;
    endcase
  end

  // Last state of the current instruction: the cycle on which Stop is
  // sampled and the retired-instruction counter advances.
  always_comb begin
    w_final = 1'b0;
    case (r_state)
      S_T2:    w_final = w_nop | w_halt | w_undef;
      S_T4:    w_final = ~(w_binary | w_muldiv);
      S_T5:    w_final = ~w_muldiv;
      S_T6:    w_final = 1'b1;
      default: w_final = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = Mem_ready ? S_T2 : S_T1;
      S_T2:    w_next = S_T3;
      S_T3:    w_next = S_T4;
      S_T4:    w_next = S_T5;
      S_T5:    w_next = S_T6;
      S_T6:    w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RST;
    endcase
    if (w_final) begin
      w_next = (w_halt | w_undef | Stop) ? S_HALT : S_T0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_RST;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_final) begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        if (w_undef) begin
          r_illegal <= 1'b1;
        end
      end
    end
  end

  // Moore control decode.
  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    ALU_op = 5'd0;
    case (r_state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        // Read/MDRin held across wait states; PC reloads only on exit.
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1; PCin = Mem_ready;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        Rout = 1'b1;
        if (w_unary) begin
          Grb = 1'b1; Zin = 1'b1; ALU_op = w_alu_code;
        end else begin
          Yin = 1'b1;
          Gra = w_muldiv;
          Grb = ~w_muldiv;
        end
      end
      S_T4: begin
        if (w_unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else begin
          Rout = 1'b1; Zin = 1'b1; ALU_op = w_alu_code;
          Grb = w_muldiv;
          Grc = ~w_muldiv;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_muldiv) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

  assign Run         = (r_state >= S_T0) && (r_state <= S_T6);
  assign Illegal     = r_illegal;
  assign Instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_sequencer
// Purpose  : Self-checking bench for alu_control_sequencer. A reference model
//            expands each instruction into its expected per-cycle control
//            list from the instruction class, then compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_sequencer;

  localparam int CW   = 4;
  localparam int MASK = (1 << CW) - 1;

  // Control vector bit masks (same order as dut_ctl below).
  localparam logic [18:0] PCOUT   = 19'd1 << 18;
  localparam logic [18:0] ZHIGH   = 19'd1 << 17;
  localparam logic [18:0] ZLOW    = 19'd1 << 16;
  localparam logic [18:0] MDROUT  = 19'd1 << 15;
  localparam logic [18:0] MARIN   = 19'd1 << 14;
  localparam logic [18:0] ZIN     = 19'd1 << 13;
  localparam logic [18:0] PCIN    = 19'd1 << 12;
  localparam logic [18:0] MDRIN   = 19'd1 << 11;
  localparam logic [18:0] IRIN    = 19'd1 << 10;
  localparam logic [18:0] YIN     = 19'd1 << 9;
  localparam logic [18:0] HIIN    = 19'd1 << 8;
  localparam logic [18:0] LOIN    = 19'd1 << 7;
  localparam logic [18:0] INCPC   = 19'd1 << 6;
  localparam logic [18:0] READ    = 19'd1 << 5;
  localparam logic [18:0] GRA     = 19'd1 << 4;
  localparam logic [18:0] GRB     = 19'd1 << 3;
  localparam logic [18:0] GRC     = 19'd1 << 2;
  localparam logic [18:0] RIN     = 19'd1 << 1;
  localparam logic [18:0] ROUT    = 19'd1 << 0;

  localparam int C_BIN = 0, C_UN = 1, C_MD = 2, C_NOP = 3, C_HALT = 4, C_UNDEF = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset, Mem_ready, Stop;
  logic [31:0]   IR;
  logic PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin;
  logic Yin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [4:0]    ALU_op;
  logic          Run, Illegal;
  logic [CW-1:0] Instr_count;
  logic [18:0]   dut_ctl;

  alu_control_sequencer #(.CNT_W(CW)) dut (
    .Clock(clk), .Reset(Reset), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .ALU_op(ALU_op), .Run(Run), .Illegal(Illegal), .Instr_count(Instr_count)
  );

  assign dut_ctl = {PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin,
                    IRin, Yin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout};

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;      // model: retired-instruction count
  bit ill;      // model: Illegal flag

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int classify(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: return C_BIN;
      5'd15, 5'd16: return C_MD;
      5'd17, 5'd18: return C_UN;
      5'd24:        return C_NOP;
      5'd27:        return C_HALT;
      default:      return C_UNDEF;
    endcase
  endfunction

  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      5'd3: return 5'd3;   5'd4: return 5'd4;   5'd5: return 5'd1;
      5'd6: return 5'd2;   5'd7: return 5'd5;   5'd8: return 5'd6;
      5'd9: return 5'd7;   5'd10: return 5'd8;  5'd15: return 5'd9;
      5'd16: return 5'd10; 5'd17: return 5'd11; 5'd18: return 5'd12;
      default: return 5'd0;
    endcase
  endfunction

  // One clock cycle: drive inputs at the negedge, check the Moore outputs,
  // then advance to the next negedge (the posedge in between commits).
  task automatic step(input string tag, input logic [18:0] ctl, input logic [4:0] alu,
                      input bit run, input bit mr, input bit st, input bit rs);
    Mem_ready = mr; Stop = st; Reset = rs;
    #1;
    check({tag, ".ctl"}, 32'(dut_ctl), 32'(ctl));
    check({tag, ".alu"}, 32'(ALU_op), 32'(alu));
    check({tag, ".run"}, 32'(Run), 32'(run));
    check({tag, ".cnt"}, 32'(Instr_count), 32'(cnt));
    check({tag, ".ill"}, 32'(Illegal), 32'(ill));
    @(negedge clk);
  endtask

  // stop_mode: 0 Stop low, 1 random each cycle, 2 Stop high from T4 onward.
  task automatic do_instr(input logic [31:0] w, input int waits, input int abort_idx,
                          input int stop_mode, output bit halted);
    logic [18:0] qc[$];
    logic [4:0]  qa[$];
    int cls, first_exec;
    logic [4:0] a;
    bit st, mr, rs;
    cls = classify(w[31:27]);
    a = alu_code(w[31:27]);
    halted = 1'b0;
    qc.push_back(PCOUT | MARIN | INCPC | ZIN); qa.push_back(5'd0);
    for (int k = 0; k <= waits; k++) begin
      qc.push_back(ZLOW | READ | MDRIN | ((k == waits) ? PCIN : 19'd0));
      qa.push_back(5'd0);
    end
    qc.push_back(MDROUT | IRIN); qa.push_back(5'd0);
    first_exec = qc.size();
    case (cls)
      C_BIN: begin
        qc.push_back(GRB | ROUT | YIN);  qa.push_back(5'd0);
        qc.push_back(GRC | ROUT | ZIN);  qa.push_back(a);
        qc.push_back(ZLOW | GRA | RIN);  qa.push_back(5'd0);
      end
      C_UN: begin
        qc.push_back(GRB | ROUT | ZIN);  qa.push_back(a);
        qc.push_back(ZLOW | GRA | RIN);  qa.push_back(5'd0);
      end
      C_MD: begin
        qc.push_back(GRA | ROUT | YIN);  qa.push_back(5'd0);
        qc.push_back(GRB | ROUT | ZIN);  qa.push_back(a);
        qc.push_back(ZLOW | LOIN);       qa.push_back(5'd0);
        qc.push_back(ZHIGH | HIIN);      qa.push_back(5'd0);
      end
      default: ;
    endcase
    IR = w;
    for (int i = 0; i < qc.size(); i++) begin
      if (i >= 1 && i <= waits)  mr = 1'b0;
      else if (i == waits + 1)   mr = 1'b1;
      else                       mr = 1'($urandom_range(0, 1));
      case (stop_mode)
        0:       st = 1'b0;
        1:       st = ($urandom_range(0, 3) == 0);
        default: st = (i >= first_exec + 1);
      endcase
      rs = (i == abort_idx);
      step("seq", qc[i], qa[i], 1'b1, mr, st, rs);
      if (rs) begin
        cnt = 0; ill = 1'b0;
        step("rst_abort", 19'd0, 5'd0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        return;
      end
      if (i == qc.size() - 1) begin
        cnt = (cnt + 1) & MASK;
        if (cls == C_UNDEF) ill = 1'b1;
        halted = (cls == C_HALT) || (cls == C_UNDEF) || st;
      end
    end
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++)
      step("halt", 19'd0, 5'd0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic reset_from_halt();
    step("halt_rst", 19'd0, 5'd0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    cnt = 0; ill = 1'b0;
    step("rst", 19'd0, 5'd0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    bit h;
    logic [4:0] op;
    int r, waits, ab, cls;
    Reset = 1'b1; Mem_ready = 1'b0; Stop = 1'b0; IR = 32'd0;
    cnt = 0; ill = 1'b0;
    @(negedge clk); @(negedge clk);
    step("rst", 19'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // and R1,R2,R3 without and with memory wait states
    do_instr(32'h28918000, 0, -1, 0, h); check("and.halted", 32'(h), 32'd0);
    do_instr(32'h28918000, 3, -1, 0, h);
    // mul R4,R5 then neg R6,R7 then halt
    do_instr(32'h7A280000, 0, -1, 0, h);
    do_instr(32'h8B380000, 1, -1, 0, h);
    do_instr(32'hD8000000, 0, -1, 0, h); check("halt.halted", 32'(h), 32'd1);
    hold_halt(10);
    reset_from_halt();
    // undefined opcode 11111
    do_instr(32'hF8000000, 0, -1, 0, h); check("undef.halted", 32'(h), 32'd1);
    hold_halt(4);
    reset_from_halt();
    // Stop held from T4 of an and
    do_instr(32'h28918000, 0, -1, 2, h); check("stop.halted", 32'(h), 32'd1);
    hold_halt(3);
    reset_from_halt();
    // Reset in T4 of an and
    do_instr(32'h28918000, 0, 4, 0, h);
    // counter wrap
    for (int i = 0; i < MASK + 2; i++) do_instr(32'hC0000000, 0, -1, 0, h);

    // randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) op = 5'd27;
      else if (r < 10) begin
        op = 5'($urandom_range(0, 31));
        while (classify(op) != C_UNDEF) op = 5'($urandom_range(0, 31));
      end
      else if (r < 25) op = 5'd24;
      else begin
        case ($urandom_range(0, 11))
          0: op = 5'd3;  1: op = 5'd4;  2: op = 5'd5;  3: op = 5'd6;
          4: op = 5'd7;  5: op = 5'd8;  6: op = 5'd9;  7: op = 5'd10;
          8: op = 5'd15; 9: op = 5'd16; 10: op = 5'd17; default: op = 5'd18;
        endcase
      end
      cls = classify(op);
      waits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      ab = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 9) : -1;
      do_instr({op, 27'($urandom)}, waits, ab,
               (cls == C_BIN || cls == C_UN || cls == C_MD) ? 1 : 0, h);
      if (h) begin
        hold_halt($urandom_range(1, 4));
        reset_from_halt();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Hardwired control unit that drives the existing Datapath bus-select and register-load strobes for fetch and execution of register-register and unary ALU instructions, plus mul/div, nop and halt.
- Replaces the hand-written T0..T5 control waveforms used in datapath testing.
- Sits beside Datapath and reads IR back from it.
- Register selection uses Gra/Grb/Grc plus Rin/Rout; the datapath's select-and-encode logic decodes IR field to register.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high.
- IR  in  32  instruction register contents from Datapath.
- Mem_ready  in  1  memory data valid on Mdatain during fetch.
- Stop  in  1  request to halt after the current instruction.
- PCout, Zhighout, Zlowout, MDRout  out  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  register load enables.
- IncPC, Read  out  1 each  PC increment, memory read.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and GP register in/out.
- ALU_op  out  5  ALU function code.
- Run  out  1  high while executing.
- Illegal  out  1  high in HALT when the halt was caused by an undefined opcode.
- Instr_count  out  CNT_W  count of retired instructions.

Behaviour:
- Instruction fields:
  - opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - Example: 0x28918000 = and R1,R2,R3.
- Opcodes:
  - 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol.
  - 01111 mul, 10000 div, 10001 neg, 10010 not, 11000 nop, 11011 halt.
  - Any other opcode is undefined.
- ALU_op encoding:
  - 0 none, 1 and, 2 or, 3 add, 4 sub, 5 shr, 6 shl, 7 ror, 8 rol, 9 mul, 10 div, 11 neg, 12 not.
  - ALU_op is nonzero only in the state that asserts Zin for execution; it is 0 in T0.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT. State is registered.
- Outputs are a Moore decode of the state plus the latched IR; all controls not listed for a state are 0.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Stays in T1 while Mem_ready=0. PCin pulses only on the cycle T1 exits; Read and MDRin are held throughout.
  - T2: MDRout, IRin. IR is valid from T3 onward.
- Binary ALU op (add..rol):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ALU_op, Zin.
  - T5: Zlowout, Gra, Rin.
  - Then T0.
- Unary op (neg, not):
  - T3: Grb, Rout, ALU_op, Zin.
  - T4: Zlowout, Gra, Rin.
  - Then T0.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, ALU_op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then T0.
- nop: T2 goes to T0.
- halt: T2 goes to HALT. Undefined opcode: T2 goes to HALT and Illegal=1.
- HALT is held until Reset; all controls 0; Run=0.
- Instr_count:
  - Increments by 1 on each transition from an instruction's final state to T0 or HALT. halt, nop and undefined count; the undefined instruction is counted.
  - Wraps from all-ones to 0.
- Stop:
  - Sampled on the cycle the final execute state exits. If Stop=1, the next state is HALT instead of T0 and Illegal=0.
  - Stop during fetch or mid-execute has no effect until that point.
- Reset:
  - At any posedge with Reset=1, the state becomes RST, Instr_count=0 and Illegal=0, regardless of state or Mem_ready.
  - RST: all controls 0, Run=0. RST goes to T0 on the first posedge with Reset=0.
  - Run=1 in T0..T6.
- An abandoned mid-instruction write never completes: Rin/HIin/LOin are not asserted after reset.
- Simultaneous Reset and Stop: Reset wins.

Test Plan:
- Preload R2=0x12 and R3=0x14, IR fetch returns 0x28918000 with Mem_ready=1 → T0..T5 in 6 cycles; ALU_op=1 with Zin in T4; Gra+Rin in T5; Instr_count 0→1; back in T0.
- Same fetch with Mem_ready low for 3 cycles → T1 held 4 cycles with Read=MDRin=1; PCin high only in the last T1 cycle; instruction otherwise identical, 9 cycles total.
- Fetch 0x7A280000 (mul R4,R5) → T3 Gra/Rout/Yin, T4 Grb/Rout/ALU_op=9/Zin, T5 Zlowout/LOin, T6 Zhighout/HIin; 7 cycles; count +1.
- Fetch 0x8B380000 (neg R6,R7) → 5 cycles, ALU_op=11 in T3, Gra/Rin in T4. Then fetch 0xD8000000 → HALT, Run=0, Illegal=0, count=2; stays halted for 10 cycles.
- Fetch opcode 11111 → HALT with Illegal=1. Separately, Stop=1 during T4 of an and instruction → T5 completes with Rin, then HALT instead of T0.
- Reset=1 asserted in T4 of an and instruction → next cycle RST, all outputs 0, Instr_count=0; Reset low → T0 on the following cycle; no Rin pulse from the aborted instruction.
